// File: rtl/seg_write_arbiter_pkg.sv
// Shared types and helpers for the seven-segment write arbiter.
package seg_pkg;

  // Width of one display digit value.
  localparam int DIGIT_W = 4;

  // Arbiter state: IDLE round-robins, LOCKED reserves the bank for one owner.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = seg_pkg::idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic         found;
  logic [W-1:0] cand;

  // Scan from ptr upward (mod N) and grant the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(ptr) + i) % N);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/seg_write_arbiter.sv
// Round-robin / lockable arbiter that owns the seven-segment digit register file.
// Handshake: a requester raises req_valid and holds index/data/lock stable;
// req_ready (combinational, one-hot, never without valid) marks the transfer
// cycle, and the digit is written on the clock edge that ends that cycle.
module seg_write_arbiter
  import seg_pkg::*;
#(
  parameter int NUM_SEGMENTS = 8,
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ-1:0][idx_w(NUM_SEGMENTS)-1:0]    req_index,
  input  logic [NUM_REQ-1:0][DIGIT_W-1:0]                req_data,
  input  logic [NUM_REQ-1:0]                             req_lock,
  output logic [NUM_SEGMENTS-1:0][DIGIT_W-1:0]           encoded,
  output logic [idx_w(NUM_REQ)-1:0]                      owner,
  output logic                                           locked,
  output logic                                           err_pulse
);

  localparam int IW      = idx_w(NUM_SEGMENTS);
  localparam int OW      = idx_w(NUM_REQ);
  localparam int CW      = idx_w(LOCK_TIMEOUT);
  localparam int TO_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

  arb_state_t           state, state_n;
  logic [OW-1:0]        rr_ptr, rr_ptr_n, owner_n;
  logic [CW-1:0]        to_cnt, to_cnt_n;
  logic                 err_n;
  logic [NUM_REQ-1:0]   owner_mask, arb_req, gnt;
  logic [OW-1:0]        gnt_idx;
  logic                 xfer, sel_lock, sel_in_range, timeout_hit;
  logic [IW-1:0]        sel_index;
  logic [DIGIT_W-1:0]   sel_data;

  // Next round-robin start position after requester g, wrapping at NUM_REQ.
  function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] g);
    return (32'(g) >= NUM_REQ - 1) ? '0 : g + OW'(1);
  endfunction

  // While locked only the owner may compete; otherwise every valid request does.
  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask[i] = (OW'(i) == owner);
    end
    arb_req = (state == ARB_LOCKED) ? (req_valid & owner_mask) : req_valid;
  end

  // Grants are suppressed during reset so ready drops immediately.
  rr_arbiter #(.N(NUM_REQ), .W(OW)) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .en      (!reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready    = gnt;
  assign xfer         = |gnt;
  assign sel_index    = req_index[gnt_idx];
  assign sel_data     = req_data[gnt_idx];
  assign sel_lock     = req_lock[gnt_idx];
  assign sel_in_range = (32'(sel_index) < NUM_SEGMENTS);
  assign locked       = (state == ARB_LOCKED);

  // The last idle locked cycle before the count reaches LOCK_TIMEOUT releases the lock.
  assign timeout_hit = (LOCK_TIMEOUT != 0) && (state == ARB_LOCKED) && !xfer &&
                       (to_cnt == CW'(TO_LAST));

  // Next-state logic: ownership, round-robin pointer, lock timeout and error pulse.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    to_cnt_n = to_cnt;
    err_n    = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (xfer) begin
          owner_n  = gnt_idx;
          rr_ptr_n = ptr_after(gnt_idx);
          to_cnt_n = '0;
          if (sel_lock) state_n = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (xfer) begin
          owner_n  = gnt_idx;
          to_cnt_n = '0;
          if (!sel_lock) begin
            state_n  = ARB_IDLE;
            rr_ptr_n = ptr_after(owner);
          end
        end else if (timeout_hit) begin
          state_n  = ARB_IDLE;
          rr_ptr_n = ptr_after(owner);
          to_cnt_n = '0;
          err_n    = 1'b1;
        end else if (LOCK_TIMEOUT != 0) begin
          to_cnt_n = to_cnt + CW'(1);
        end
      end
      default: state_n = ARB_IDLE;
    endcase
    if (xfer && !sel_in_range) err_n = 1'b1;
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      to_cnt    <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      to_cnt    <= to_cnt_n;
      err_pulse <= err_n;
    end
  end

  // Digit register file: write the granted digit, skip out-of-range positions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      encoded <= '0;
    end else if (xfer && sel_in_range) begin
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        if (32'(sel_index) == s) encoded[s] <= sel_data;
      end
    end
  end

endmodule
